host_mem_rd_page_splitter: RTL and testbench

HOST_MEM_RD_PAGE_SPLITTER -- requirements
Module: host_mem_rd_page_splitter

---
 rtl/host_mem_rd_page_splitter.sv | 82 ++++++++
 tb/tb_host_mem_rd_page_splitter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/host_mem_rd_page_splitter.sv
// host_mem_rd_page_splitter: splits DMA read bursts at page boundaries and meters outstanding lines
module host_mem_rd_page_splitter #(
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int PAGE_LINES = 64,
  parameter int MAX_OUTSTANDING_LINES = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       src_rd_read,
  input  logic [ADDR_WIDTH-1:0]      src_rd_address,
  input  logic [BURST_CNT_WIDTH-1:0] src_rd_burstcount,
  output logic                       src_rd_waitrequest,
  output logic [DATA_WIDTH-1:0]      src_rd_readdata,
  output logic                       src_rd_readdatavalid,
  output logic                       snk_rd_read,
  output logic [ADDR_WIDTH-1:0]      snk_rd_address,
  output logic [BURST_CNT_WIDTH-1:0] snk_rd_burstcount,
  input  logic                       snk_rd_waitrequest,
  input  logic [DATA_WIDTH-1:0]      snk_rd_readdata,
  input  logic                       snk_rd_readdatavalid,
  output logic                       err_zero_burst,
  output logic                       busy
);
  localparam int PW = $clog2(PAGE_LINES);
  localparam int OW = $clog2(MAX_OUTSTANDING_LINES + 1);
  localparam int RW = (BURST_CNT_WIDTH > PW + 1) ? BURST_CNT_WIDTH : PW + 1;
  localparam int SW = ((OW > BURST_CNT_WIDTH) ? OW : BURST_CNT_WIDTH) + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;
  logic [0:0] state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [BURST_CNT_WIDTH-1:0] remaining;
  logic [OW-1:0] outstanding;
  logic err_q;
  logic [RW-1:0] room, piece;
  logic [SW-1:0] demand, sum;
  logic src_acc, snk_acc, last_piece;
  // piece sizing, credit check and handshakes; reset forces the idle-looking outputs
  always_comb begin
    room = RW'(PAGE_LINES) - RW'(cur_addr[PW-1:0]);
    piece = (RW'(remaining) < room) ? RW'(remaining) : room;
    last_piece = RW'(remaining) == piece;
    demand = SW'(outstanding) + SW'(src_rd_burstcount);
    src_rd_waitrequest = reset || state == ISSUE || demand > SW'(MAX_OUTSTANDING_LINES);
    src_acc = src_rd_read && !src_rd_waitrequest;
    snk_rd_read = !reset && state == ISSUE;
    snk_acc = snk_rd_read && !snk_rd_waitrequest;
    sum = src_acc ? demand : SW'(outstanding);
  end
  assign snk_rd_address = cur_addr;
  assign snk_rd_burstcount = BURST_CNT_WIDTH'(piece);
  assign src_rd_readdata = snk_rd_readdata;
  assign src_rd_readdatavalid = snk_rd_readdatavalid;
  assign err_zero_burst = err_q && !reset;
  assign busy = !reset && (state == ISSUE || outstanding != '0);
  // FSM: latch a source burst, then walk it out one page-bounded piece per sink accept
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cur_addr <= '0;
      remaining <= '0;
    end else if (src_acc) begin
      cur_addr <= src_rd_address;
      remaining <= src_rd_burstcount;
      state <= (src_rd_burstcount != '0) ? ISSUE : IDLE;
    end else if (snk_acc) begin
      cur_addr <= cur_addr + ADDR_WIDTH'(piece);
      remaining <= remaining - BURST_CNT_WIDTH'(piece);
      state <= last_piece ? IDLE : ISSUE;
    end
  // outstanding-line credit (saturating at 0) and the zero-burst error pulse
  always_ff @(posedge clk)
    if (reset) begin
      outstanding <= '0;
      err_q <= 1'b0;
    end else begin
      outstanding <= OW'((snk_rd_readdatavalid && sum != '0) ? sum - 1'b1 : sum);
      err_q <= src_acc && src_rd_burstcount == '0;
    end
endmodule

// File: tb/tb_host_mem_rd_page_splitter.sv
// tb_host_mem_rd_page_splitter: scoreboard bench for the page splitter
module tb_host_mem_rd_page_splitter;
  localparam int AW = 42;
  localparam int DW = 512;
  localparam int BW = 7;
  typedef struct {
    logic [AW-1:0] addr;
    int bc;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic src_rd_read = 1'b0;
  logic [AW-1:0] src_rd_address = '0;
  logic [BW-1:0] src_rd_burstcount = '0;
  logic src_rd_waitrequest;
  logic [DW-1:0] src_rd_readdata;
  logic src_rd_readdatavalid;
  logic snk_rd_read;
  logic [AW-1:0] snk_rd_address;
  logic [BW-1:0] snk_rd_burstcount;
  logic snk_rd_waitrequest = 1'b0;
  logic [DW-1:0] snk_rd_readdata = '0;
  logic snk_rd_readdatavalid = 1'b0;
  logic err_zero_burst;
  logic busy;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t q[$];
  host_mem_rd_page_splitter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW),
    .PAGE_LINES(64), .MAX_OUTSTANDING_LINES(128)
  ) dut (
    .clk(clk), .reset(reset),
    .src_rd_read(src_rd_read), .src_rd_address(src_rd_address),
    .src_rd_burstcount(src_rd_burstcount), .src_rd_waitrequest(src_rd_waitrequest),
    .src_rd_readdata(src_rd_readdata), .src_rd_readdatavalid(src_rd_readdatavalid),
    .snk_rd_read(snk_rd_read), .snk_rd_address(snk_rd_address),
    .snk_rd_burstcount(snk_rd_burstcount), .snk_rd_waitrequest(snk_rd_waitrequest),
    .snk_rd_readdata(snk_rd_readdata), .snk_rd_readdatavalid(snk_rd_readdatavalid),
    .err_zero_burst(err_zero_burst), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // monitor: every accepted sink request must match the head of the scoreboard
  always @(negedge clk)
    if (snk_rd_read && !snk_rd_waitrequest) begin : mon
      exp_t e;
      chk("issue_holds_src_wait", 64'(src_rd_waitrequest), 64'd1);
      chk("no_page_cross", 64'(64'(snk_rd_address[5:0]) + 64'(snk_rd_burstcount) <= 64), 64'd1);
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_sink_req: got addr %0h bc %0d expected none", snk_rd_address, snk_rd_burstcount);
      end else begin
        e = q.pop_front();
        chk("sink_addr", 64'(snk_rd_address), 64'(e.addr));
        chk("sink_bc", 64'(snk_rd_burstcount), 64'(e.bc));
        if (e.cyc >= 0) chk("sink_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  task automatic push(input logic [AW-1:0] a, input int bc, input int c);
    exp_t e;
    e.addr = a;
    e.bc = bc;
    e.cyc = c;
    q.push_back(e);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    src_rd_read = 1'b0;
    src_rd_burstcount = '0;
    snk_rd_waitrequest = 1'b0;
    snk_rd_readdatavalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_snk_read", 64'(snk_rd_read), 64'd0);
    chk("rst_src_wait", 64'(src_rd_waitrequest), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_zero_burst), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask
  task automatic src_req(input logic [AW-1:0] a, input int bc, output int ac);
    bit ok = 0;
    ac = -1;
    src_rd_read = 1'b1;
    src_rd_address = a;
    src_rd_burstcount = BW'(bc);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!src_rd_waitrequest) begin
        ok = 1;
        ac = cyc;
      end
    end
    chk("src_accept_in_time", 64'(ok), 64'd1);
    @(posedge clk);
    #1 src_rd_read = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
  endtask
  initial begin
    int ac;
    do_reset();
    // aligned single-page burst
    src_req(42'h100, 64, ac);
    push(42'h100, 64, ac + 1);
    @(negedge clk);
    chk("aligned_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("aligned_back_idle", 64'(snk_rd_read), 64'd0);
    drain();
    do_reset();
    // page crossing, back-to-back pieces
    src_req(42'h13C, 8, ac);
    push(42'h13C, 4, ac + 1);
    push(42'h140, 4, ac + 2);
    drain();
    do_reset();
    // backpressure on the second piece
    src_req(42'h13C, 8, ac);
    push(42'h13C, 4, ac + 1);
    push(42'h140, 4, ac + 5);
    @(posedge clk);
    #1 snk_rd_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_read", 64'(snk_rd_read), 64'd1);
      chk("bp_addr", 64'(snk_rd_address), 64'h140);
      chk("bp_bc", 64'(snk_rd_burstcount), 64'd4);
      chk("bp_src_wait", 64'(src_rd_waitrequest), 64'd1);
    end
    @(posedge clk);
    #1 snk_rd_waitrequest = 1'b0;
    @(negedge clk);
    chk("bp_addr_last", 64'(snk_rd_address), 64'h140);
    chk("bp_src_wait_last", 64'(src_rd_waitrequest), 64'd1);
    drain();
    do_reset();
    // credit limit of 128 lines
    src_req(42'h0, 64, ac);
    push(42'h0, 64, ac + 1);
    src_req(42'h40, 64, ac);
    push(42'h40, 64, ac + 1);
    @(posedge clk);
    #1;
    src_rd_read = 1'b1;
    src_rd_address = 42'h80;
    src_rd_burstcount = BW'(64);
    snk_rd_readdatavalid = 1'b1;
    snk_rd_readdata = {8{64'hA5A5_0000_0000_0000}};
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      chk("credit_wait", 64'(src_rd_waitrequest), 64'd1);
      chk("credit_busy", 64'(busy), 64'd1);
      chk("pass_valid", 64'(src_rd_readdatavalid), 64'd1);
      chk("pass_data", src_rd_readdata[63:0], 64'hA5A5_0000_0000_0000 ^ 64'(k));
      @(posedge clk);
      #1 snk_rd_readdata = {8{64'hA5A5_0000_0000_0000 ^ 64'(k + 1)}};
    end
    snk_rd_readdatavalid = 1'b0;
    @(negedge clk);
    chk("credit_accept_at_64", 64'(src_rd_waitrequest), 64'd0);
    chk("pass_valid_low", 64'(src_rd_readdatavalid), 64'd0);
    ac = cyc;
    @(posedge clk);
    #1 src_rd_read = 1'b0;
    push(42'h80, 64, ac + 1);
    drain();
    do_reset();
    // zero burst
    src_req(42'h200, 0, ac);
    @(negedge clk);
    chk("zb_err_pulse", 64'(err_zero_burst), 64'd1);
    chk("zb_no_read", 64'(snk_rd_read), 64'd0);
    chk("zb_not_busy", 64'(busy), 64'd0);
    chk("zb_still_idle", 64'(src_rd_waitrequest), 64'd0);
    @(negedge clk);
    chk("zb_err_clear", 64'(err_zero_burst), 64'd0);
    chk("zb_no_read2", 64'(snk_rd_read), 64'd0);
    chk("zb_not_busy2", 64'(busy), 64'd0);
    drain();
    do_reset();
    // reset in the middle of a split
    src_req(42'h13C, 8, ac);
    push(42'h13C, 4, ac + 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mr_read_in_rst", 64'(snk_rd_read), 64'd0);
    chk("mr_wait_in_rst", 64'(src_rd_waitrequest), 64'd1);
    chk("mr_busy_in_rst", 64'(busy), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mr_read_after", 64'(snk_rd_read), 64'd0);
    chk("mr_busy_after", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    snk_rd_readdatavalid = 1'b1;
    snk_rd_readdata = {8{64'h0123_4567_89AB_CDEF}};
    @(negedge clk);
    chk("mr_late_valid", 64'(src_rd_readdatavalid), 64'd1);
    chk("mr_late_data", src_rd_readdata[63:0], 64'h0123_4567_89AB_CDEF);
    @(posedge clk);
    #1 snk_rd_readdatavalid = 1'b0;
    @(negedge clk);
    chk("mr_outstanding_sat", 64'(busy), 64'd0);
    chk("mr_no_second_piece", 64'(snk_rd_read), 64'd0);
    repeat (3) @(negedge clk);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
